// File: rtl/ex_pkg.sv
// Shared opcode, condition-code and flag-index definitions for the execute stage,
// plus the branch condition evaluator.
package ex_pkg;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MOVE,
    CLS_BRANCH
  } op_class_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_NOT = 3'b110;

  localparam logic [2:0] MV_MOV  = 3'b000;
  localparam logic [2:0] MV_MOVT = 3'b001;
  localparam logic [2:0] MV_CLR  = 3'b010;
  localparam logic [2:0] MV_SET  = 3'b011;
  localparam logic [2:0] MV_LSL  = 3'b100;
  localparam logic [2:0] MV_LSR  = 3'b101;

  localparam logic [2:0] BR_B     = 3'b000;
  localparam logic [2:0] BR_BCOND = 3'b001;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, c, z, v;
    n = f[FLAG_N];
    c = f[FLAG_C];
    z = f[FLAG_Z];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !(c && !z);
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return !(!z && (n == v));
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_shifter.sv
// Logical shifter with start/done handshake: combinational barrel shift, or one bit per
// cycle when SHIFT_ITER=1. Zero-amount and oversize shifts complete in the start cycle.
module ex_shifter
  import ex_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int SHIFT_ITER = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              start,
  input  logic              dir_left,
  input  logic [DATA_W-1:0] value,
  input  logic [IMM_W-1:0]  amount,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  logic too_big;
  assign too_big = 32'(amount) >= DATA_W;

  if (SHIFT_ITER == 0) begin : g_barrel
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, abort};
    assign done      = start;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      result = '0;
      if (!too_big) result = dir_left ? (value << amount) : (value >> amount);
    end
  end else begin : g_iter
    logic              busy;
    logic              left;
    logic [IMM_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic              imm_done;

    assign imm_done = too_big || (amount == '0);
    assign done     = (start && imm_done) || (busy && cnt == '0);
    assign result   = busy ? acc : (too_big ? '0 : value);

    // The first bit is shifted on the start edge, so an N-bit shift finishes N edges later.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy <= 1'b0;
        left <= 1'b0;
        cnt  <= '0;
        acc  <= '0;
      end else if (abort) begin
        busy <= 1'b0;
      end else if (start && !imm_done) begin
        busy <= 1'b1;
        left <= dir_left;
        cnt  <= amount - 1'b1;
        acc  <= dir_left ? (value << 1) : (value >> 1);
      end else if (busy) begin
        if (cnt == '0) begin
          busy <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
          acc <= left ? (acc << 1) : (acc >> 1);
        end
      end
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: ALU, data moves, shifts and branch resolution against the
// CPSR flags, with valid/ready handshakes and a single op in flight.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int RADDR_W    = 3,
  parameter int SHIFT_ITER = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         first_ld,
  input  logic               special_enc,
  input  logic [3:0]         second_ld,
  input  logic [2:0]         alu_oc,
  input  logic [3:0]         b_cond,
  input  logic [RADDR_W-1:0] dest_reg,
  input  logic [DATA_W-1:0]  op1,
  input  logic [DATA_W-1:0]  op2,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [IMM_W-1:0]   offset,
  input  logic [DATA_W-1:0]  pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RADDR_W-1:0] out_dest,
  output logic               out_wr_en,
  output logic               br_taken,
  output logic [DATA_W-1:0]  br_target,
  output logic [3:0]         flags
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  state_t state;

  logic              accept, is_shift, sh_done;
  logic [DATA_W-1:0] sh_result, imm_sext, off_sext, alu_b;
  op_class_t         op_class;
  logic              unused_ok;

  assign unused_ok = ^second_ld[2:0];
  assign in_ready  = (state == ST_IDLE) && !out_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign imm_sext  = DATA_W'($signed(immediate));
  assign off_sext  = DATA_W'($signed(offset));
  assign alu_b     = first_ld[0] ? op2 : imm_sext;
  assign op_class  = special_enc ? CLS_ALU : (first_ld == 2'b00 ? CLS_MOVE : CLS_BRANCH);
  assign is_shift  = (op_class == CLS_MOVE) && (alu_oc == MV_LSL || alu_oc == MV_LSR);

  ex_shifter #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SHIFT_ITER(SHIFT_ITER)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (flush),
    .start    (accept && is_shift),
    .dir_left (alu_oc == MV_LSL),
    .value    (op1),
    .amount   (immediate),
    .done     (sh_done),
    .result   (sh_result)
  );

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res, mv_res, ex_result;
  logic [3:0]        alu_flags;
  logic              alu_wr, mv_wr, ex_wr, ex_br;

  always_comb begin
    sum       = {1'b0, op1} + {1'b0, alu_b};
    alu_res   = '0;
    alu_wr    = 1'b1;
    alu_flags = flags;
    case (alu_oc)
      ALU_ADD: begin
        alu_res           = sum[DATA_W-1:0];
        alu_flags[FLAG_C] = sum[DATA_W];
        alu_flags[FLAG_V] = (op1[DATA_W-1] == alu_b[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != op1[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res           = op1 - alu_b;
        alu_flags[FLAG_C] = op1 >= alu_b;
        alu_flags[FLAG_V] = (op1[DATA_W-1] != alu_b[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != op1[DATA_W-1]);
      end
      ALU_AND: alu_res = op1 & alu_b;
      ALU_OR:  alu_res = op1 | alu_b;
      ALU_XOR: alu_res = op1 ^ alu_b;
      ALU_NOT: alu_res = ~op1;
      default: alu_wr  = 1'b0;
    endcase
    alu_flags[FLAG_N] = alu_res[DATA_W-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  always_comb begin
    mv_res = '0;
    mv_wr  = 1'b1;
    case (alu_oc)
      MV_MOV:  mv_res = imm_sext;
      MV_MOVT: begin
        mv_res = op1;
        for (int i = 0; i < 16; i++)
          if (i + 16 < DATA_W) mv_res[i + 16] = immediate[i];
      end
      MV_CLR:  mv_res = '0;
      MV_SET:  mv_res = '1;
      MV_LSL, MV_LSR: mv_res = sh_result;
      default: mv_wr  = 1'b0;
    endcase
  end

  always_comb begin
    ex_result = '0;
    ex_wr     = 1'b0;
    ex_br     = 1'b0;
    case (op_class)
      CLS_ALU:  begin ex_result = alu_res; ex_wr = alu_wr; end
      CLS_MOVE: begin ex_result = mv_res;  ex_wr = mv_wr;  end
      default:  ex_br = (alu_oc == BR_B) || (alu_oc == BR_BCOND && cond_pass(b_cond, flags));
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dest   <= '0;
      out_wr_en  <= 1'b0;
      br_taken   <= 1'b0;
      br_target  <= '0;
      flags      <= 4'b0000;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_wr_en <= 1'b0;
      br_taken  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          out_dest  <= dest_reg;
          br_target <= pc + off_sext;
          if (op_class == CLS_ALU && second_ld[3] && alu_wr) flags <= alu_flags;
          if (is_shift && !sh_done) begin
            state <= ST_SHIFT;
          end else begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            out_result <= ex_result;
            out_wr_en  <= ex_wr;
            br_taken   <= ex_br;
          end
        end
        ST_SHIFT: if (sh_done) begin
          state      <= ST_DONE;
          out_valid  <= 1'b1;
          out_result <= sh_result;
          out_wr_en  <= 1'b1;
          br_taken   <= 1'b0;
        end
        ST_DONE: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: an iterative-shift instance carries most vectors,
// a barrel-shift instance sharing the operand inputs covers single-cycle shifts.
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        in_valid, b_in_valid, in_ready, b_in_ready;
  logic [1:0]  first_ld;
  logic        special_enc;
  logic [3:0]  second_ld, b_cond;
  logic [2:0]  alu_oc, dest_reg;
  logic [31:0] op1, op2, pc;
  logic [15:0] immediate, offset;
  logic        out_valid, b_out_valid, out_ready, b_out_ready;
  logic [31:0] out_result, b_out_result, br_target, b_br_target;
  logic [2:0]  out_dest, b_out_dest;
  logic        out_wr_en, b_out_wr_en, br_taken, b_br_taken;
  logic [3:0]  flags, b_flags;

  int n_cmp = 0;
  int n_err = 0;
  int lat, hi, cnt_a, cnt_b;

  always #5 clk = ~clk;

  ex_stage_pipe #(.DATA_W(32), .IMM_W(16), .RADDR_W(3), .SHIFT_ITER(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .first_ld(first_ld), .special_enc(special_enc), .second_ld(second_ld), .alu_oc(alu_oc),
    .b_cond(b_cond), .dest_reg(dest_reg), .op1(op1), .op2(op2), .immediate(immediate),
    .offset(offset), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_wr_en(out_wr_en),
    .br_taken(br_taken), .br_target(br_target), .flags(flags)
  );

  ex_stage_pipe #(.DATA_W(32), .IMM_W(16), .RADDR_W(3), .SHIFT_ITER(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .first_ld(first_ld), .special_enc(special_enc), .second_ld(second_ld), .alu_oc(alu_oc),
    .b_cond(b_cond), .dest_reg(dest_reg), .op1(op1), .op2(op2), .immediate(immediate),
    .offset(offset), .pc(pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_dest(b_out_dest), .out_wr_en(b_out_wr_en),
    .br_taken(b_br_taken), .br_target(b_br_target), .flags(b_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic se, input logic [1:0] fl, input logic [3:0] sl,
                        input logic [2:0] oc, input logic [3:0] cond, input logic [2:0] dst,
                        input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                        input logic [15:0] off, input logic [31:0] p);
    special_enc = se; first_ld = fl; second_ld = sl; alu_oc = oc; b_cond = cond;
    dest_reg = dst; op1 = a; op2 = b; immediate = imm; offset = off; pc = p;
  endtask

  // Present the op until accepted, then wait (bounded) for out_valid; lat counts the
  // accept edge as cycle 1, hi counts cycles where in_ready was high while waiting.
  task automatic run(input bit sel, input string tag, output int l, output int h);
    int  guard;
    logic v;
    guard = 0;
    @(negedge clk);
    if (sel) b_in_valid = 1'b1; else in_valid = 1'b1;
    while (!(sel ? b_in_ready : in_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_accept"}, sel ? b_in_ready : in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    b_in_valid = 1'b0;
    l = 0;
    h = 0;
    do begin
      @(negedge clk);
      l++;
      v = sel ? b_out_valid : out_valid;
      if (!v && (sel ? b_in_ready : in_ready)) h++;
    end while (!v && l < 200);
    check({tag, "_valid"}, v, 1'b1);
  endtask

  task automatic take(input bit sel);
    if (sel) b_out_ready = 1'b1; else out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    b_out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; b_in_valid = 1'b0;
    out_ready = 1'b0; b_out_ready = 1'b0;
    set_op(0, 2'b00, 4'h0, 3'd0, 4'h0, 3'd0, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_flags", flags, 4'b0000);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_br", {br_taken, out_wr_en}, 2'b00);
    check("rst_br_target", br_target, 32'h0);
    rst_n = 1'b1;

    // ADD S=1 with signed overflow, one-cycle latency
    set_op(1, 2'b00, 4'h8, 3'b001, 4'h0, 3'd1, 32'h7FFFFFFF, 32'h0, 16'h0001, 16'h0, 32'h0);
    run(0, "add", lat, hi);
    check("add_res", out_result, 32'h80000000);
    check("add_flags", flags, 4'b1001);
    check("add_lat", lat, 1);
    check("add_wr", {out_wr_en, out_dest}, 4'b1001);

    // Backpressure: another op waits while the ADD result is held
    set_op(0, 2'b00, 4'h0, 3'b010, 4'h0, 3'd5, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0);
    in_valid = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid && out_result == 32'h80000000 && out_dest == 3'd1) cnt_a++;
      if (in_ready) cnt_b++;
    end
    in_valid = 1'b0;
    check("bp_stable", cnt_a, 5);
    check("bp_in_ready", cnt_b, 0);
    take(0);
    @(negedge clk);
    check("bp_no_second", out_valid, 1'b0);

    // SUB S=1 reg operand -> zero, then BEQ / BNE / B with wrap
    set_op(1, 2'b01, 4'h8, 3'b010, 4'h0, 3'd2, 32'd5, 32'd5, 16'h0, 16'h0, 32'h0);
    run(0, "sub", lat, hi);
    check("sub_res", out_result, 32'h0);
    check("sub_flags", flags, 4'b0110);
    take(0);
    set_op(0, 2'b01, 4'h0, 3'b001, 4'h0, 3'd0, 32'h0, 32'h0, 16'h0, 16'hFFFC, 32'h100);
    run(0, "beq", lat, hi);
    check("beq_taken", br_taken, 1'b1);
    check("beq_target", br_target, 32'h000000FC);
    check("beq_wr", out_wr_en, 1'b0);
    take(0);
    set_op(0, 2'b01, 4'h0, 3'b001, 4'h1, 3'd0, 32'h0, 32'h0, 16'h0, 16'h0010, 32'h200);
    run(0, "bne", lat, hi);
    check("bne_taken", br_taken, 1'b0);
    check("bne_target", br_target, 32'h00000210);
    take(0);
    set_op(0, 2'b10, 4'h0, 3'b000, 4'hF, 3'd0, 32'h0, 32'h0, 16'h0, 16'h0004, 32'hFFFFFFFE);
    run(0, "b_wrap", lat, hi);
    check("b_wrap_taken", br_taken, 1'b1);
    check("b_wrap_target", br_target, 32'h00000002);
    take(0);

    // Data moves leave flags alone
    set_op(0, 2'b00, 4'h8, 3'b001, 4'h0, 3'd3, 32'h00001234, 32'h0, 16'hABCD, 16'h0, 32'h0);
    run(0, "movt", lat, hi);
    check("movt_res", out_result, 32'hABCD1234);
    check("movt_flags", flags, 4'b0110);
    take(0);
    set_op(0, 2'b00, 4'h8, 3'b011, 4'h0, 3'd4, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0);
    run(0, "set", lat, hi);
    check("set_res", out_result, 32'hFFFFFFFF);
    check("set_flags", flags, 4'b0110);
    take(0);
    set_op(0, 2'b00, 4'h0, 3'b000, 4'h0, 3'd4, 32'h0, 32'h0, 16'h8000, 16'h0, 32'h0);
    run(0, "mov", lat, hi);
    check("mov_res", out_result, 32'hFFFF8000);
    take(0);

    // Logic op: N/Z update, C/V kept; then condition checks
    set_op(1, 2'b01, 4'h8, 3'b101, 4'h0, 3'd1, 32'h80000000, 32'h1, 16'h0, 16'h0, 32'h0);
    run(0, "xor", lat, hi);
    check("xor_res", out_result, 32'h80000001);
    check("xor_flags", flags, 4'b1100);
    take(0);
    set_op(0, 2'b01, 4'h0, 3'b001, 4'hA, 3'd0, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0);
    run(0, "bge", lat, hi);
    check("bge_taken", br_taken, 1'b0);
    take(0);
    set_op(0, 2'b01, 4'h0, 3'b001, 4'h8, 3'd0, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0);
    run(0, "bhi", lat, hi);
    check("bhi_taken", br_taken, 1'b1);
    take(0);
    set_op(1, 2'b01, 4'h8, 3'b000, 4'h0, 3'd1, 32'h12345678, 32'h0, 16'h0, 16'h0, 32'h0);
    run(0, "alu_nop", lat, hi);
    check("alu_nop_wr", out_wr_en, 1'b0);
    check("alu_nop_flags", flags, 4'b1100);
    take(0);
    set_op(1, 2'b00, 4'h0, 3'b010, 4'h0, 3'd1, 32'd3, 32'h0, 16'd5, 16'h0, 32'h0);
    run(0, "sub_nos", lat, hi);
    check("sub_nos_res", out_result, 32'hFFFFFFFE);
    check("sub_nos_flags", flags, 4'b1100);
    take(0);
    set_op(1, 2'b01, 4'h8, 3'b010, 4'h0, 3'd1, 32'd3, 32'd5, 16'h0, 16'h0, 32'h0);
    run(0, "sub_brw", lat, hi);
    check("sub_brw_flags", flags, 4'b1000);
    take(0);
    set_op(0, 2'b01, 4'h0, 3'b001, 4'h3, 3'd0, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0);
    run(0, "bcc", lat, hi);
    check("bcc_taken", br_taken, 1'b1);
    take(0);
    set_op(1, 2'b00, 4'h8, 3'b001, 4'h0, 3'd1, 32'hFFFFFFFF, 32'h0, 16'h0001, 16'h0, 32'h0);
    run(0, "add_c", lat, hi);
    check("add_c_res", out_result, 32'h0);
    check("add_c_flags", flags, 4'b0110);
    take(0);
    set_op(1, 2'b00, 4'h0, 3'b110, 4'h0, 3'd1, 32'h0000FFFF, 32'h0, 16'h0, 16'h0, 32'h0);
    run(0, "not", lat, hi);
    check("not_res", out_result, 32'hFFFF0000);
    take(0);

    // Iterative shifts
    set_op(0, 2'b00, 4'h0, 3'b100, 4'h0, 3'd7, 32'h1, 32'h0, 16'd31, 16'h0, 32'h0);
    run(0, "lsl31", lat, hi);
    check("lsl31_res", out_result, 32'h80000000);
    check("lsl31_lat", lat, 32);
    check("lsl31_in_ready", hi, 0);
    check("lsl31_dest", {out_wr_en, out_dest}, 4'b1111);
    take(0);
    set_op(0, 2'b00, 4'h0, 3'b100, 4'h0, 3'd7, 32'h1, 32'h0, 16'd40, 16'h0, 32'h0);
    run(0, "lsl40", lat, hi);
    check("lsl40_res", out_result, 32'h0);
    take(0);
    set_op(0, 2'b00, 4'h0, 3'b101, 4'h0, 3'd7, 32'h80000000, 32'h0, 16'd4, 16'h0, 32'h0);
    run(0, "lsr4", lat, hi);
    check("lsr4_res", out_result, 32'h08000000);
    check("lsr4_lat", lat, 5);
    take(0);
    set_op(0, 2'b00, 4'h0, 3'b100, 4'h0, 3'd7, 32'h5, 32'h0, 16'd0, 16'h0, 32'h0);
    run(0, "lsl0", lat, hi);
    check("lsl0_res", out_result, 32'h5);
    check("lsl0_lat", lat, 1);
    take(0);

    // Barrel shifts on the single-cycle instance
    set_op(0, 2'b00, 4'h0, 3'b101, 4'h0, 3'd2, 32'hF0000000, 32'h0, 16'd28, 16'h0, 32'h0);
    run(1, "b_lsr28", lat, hi);
    check("b_lsr28_res", b_out_result, 32'h0000000F);
    check("b_lsr28_lat", lat, 1);
    take(1);
    set_op(0, 2'b00, 4'h0, 3'b100, 4'h0, 3'd2, 32'hFFFFFFFF, 32'h0, 16'd32, 16'h0, 32'h0);
    run(1, "b_lsl32", lat, hi);
    check("b_lsl32_res", b_out_result, 32'h0);
    take(1);

    // Flush together with in_valid drops the op
    set_op(0, 2'b00, 4'h0, 3'b011, 4'h0, 3'd2, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) cnt_a++;
    end
    check("flush_drop", cnt_a, 0);

    // Flush mid-shift aborts it; the stage then runs a fresh op
    set_op(0, 2'b00, 4'h0, 3'b100, 4'h0, 3'd6, 32'h1, 32'h0, 16'd31, 16'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt_a++;
    end
    check("flush_shift_none", cnt_a, 0);
    check("flush_shift_ready", in_ready, 1'b1);
    check("flush_flags_kept", flags, 4'b0110);
    set_op(0, 2'b00, 4'h0, 3'b011, 4'h0, 3'd6, 32'h0, 32'h0, 16'h0, 16'h0, 32'h0);
    run(0, "post_flush", lat, hi);
    check("post_flush_res", out_result, 32'hFFFFFFFF);
    check("post_flush_lat", lat, 1);
    take(0);

    // Asynchronous reset in the middle of a shift
    set_op(0, 2'b00, 4'h0, 3'b100, 4'h0, 3'd6, 32'h1, 32'h0, 16'd20, 16'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_result", out_result, 32'h0);
    check("rst_mid_flags", flags, 4'b0000);
    check("rst_mid_ctl", {out_valid, out_wr_en, br_taken, in_ready}, 4'b0001);
    check("rst_mid_dest", out_dest, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) cnt_a++;
    end
    check("rst_mid_no_out", cnt_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
